// File: rtl/sumador_secuencial.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, result after WIDTH/DIGIT cycles.
// Handshake: start is accepted only in IDLE; done pulses one cycle with S/C_out/V freshly updated.
module sumador_secuencial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resta,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("sumador_secuencial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cmsb_q, cmsb_d;
  logic             cout_q, cout_d, v_q, v_d, done_q, done_d;

  logic [DIGIT-1:0] slice;
  logic             slice_cout, slice_cmsb;

  // Bit-level ripple across one digit; the carry entering the top bit is kept for overflow.
  always_comb begin : ripple
    logic c;
    c          = carry_q;
    slice      = '0;
    slice_cmsb = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) slice_cmsb = c;
      slice[i] = a_q[i] ^ b_q[i] ^ c;
      c        = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    slice_cout = c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{resta}};
          carry_d = C_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New slice enters at the top so the result ends up aligned after N shifts.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cmsb_d  = slice_cmsb;
          state_d = DONE;
        end
      end
      DONE: begin
        s_d     = sum_q;
        cout_d  = carry_q;
        v_d     = carry_q ^ cmsb_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign S         = s_q;
  assign C_out     = cout_q;
  assign V         = v_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sumador_secuencial.sv
// Bench for sumador_secuencial: default (8,2) instance plus (8,8) and (16,1) instances
// sharing operand inputs, each with its own start.
module tb_sumador_secuencial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_m = 1'b0, start_8 = 1'b0, start_16 = 1'b0;
  logic        resta = 1'b0, C_in = 1'b0;
  logic [15:0] A = '0, B = '0;

  logic [7:0]  s_m, s_8;
  logic [15:0] s_16;
  logic        co_m, co_8, co_16, v_m, v_8, v_16;
  logic        busy_m, busy_8, busy_16, done_m, done_8, done_16;
  logic [1:0]  st_m, st_8, st_16;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          sel      = 0;
  logic [15:0] last_s[3];

  logic [15:0] sel_s;
  logic        sel_co, sel_v, sel_busy, sel_done;

  always #5 clk = ~clk;

  sumador_secuencial #(.WIDTH(8), .DIGIT(2)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .resta(resta), .A(A[7:0]), .B(B[7:0]), .C_in(C_in),
    .S(s_m), .C_out(co_m), .V(v_m), .busy(busy_m), .done(done_m), .dbg_state(st_m));

  sumador_secuencial #(.WIDTH(8), .DIGIT(8)) dut_8 (
    .clk(clk), .rst(rst), .start(start_8), .resta(resta), .A(A[7:0]), .B(B[7:0]), .C_in(C_in),
    .S(s_8), .C_out(co_8), .V(v_8), .busy(busy_8), .done(done_8), .dbg_state(st_8));

  sumador_secuencial #(.WIDTH(16), .DIGIT(1)) dut_16 (
    .clk(clk), .rst(rst), .start(start_16), .resta(resta), .A(A), .B(B), .C_in(C_in),
    .S(s_16), .C_out(co_16), .V(v_16), .busy(busy_16), .done(done_16), .dbg_state(st_16));

  always_comb begin
    sel_s = {8'h00, s_m}; sel_co = co_m; sel_v = v_m; sel_busy = busy_m; sel_done = done_m;
    case (sel)
      1: begin sel_s = {8'h00, s_8}; sel_co = co_8; sel_v = v_8; sel_busy = busy_8; sel_done = done_8; end
      2: begin sel_s = s_16; sel_co = co_16; sel_v = v_16; sel_busy = busy_16; sel_done = done_16; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int which, input logic val);
    case (which)
      0: start_m = val;
      1: start_8 = val;
      default: start_16 = val;
    endcase
  endtask

  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic rs);
    logic [16:0] mask, aa, bb, sum, s;
    logic        v;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & mask;
    bb   = (rs ? ~{1'b0, b} : {1'b0, b}) & mask;
    sum  = aa + bb + {16'd0, cin};
    s    = sum & mask;
    v    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {v, sum[w], s[15:0]};
  endfunction

  // One operation on the selected instance; inputs are scrambled while it runs.
  task automatic run_op(input int which, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic rs, input logic [15:0] es,
                        input logic ec, input logic ev, input logic pulse, input string tag);
    int n, lat, busy_cnt, extra;
    n = (which == 0) ? 4 : (which == 1) ? 1 : 16;
    sel = which;
    @(negedge clk);
    A = a; B = b; C_in = cin; resta = rs;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    lat = -1; busy_cnt = 0;
    for (int i = 0; i < n + 6 && lat < 0; i++) begin
      check({tag, "_busy_and_done"}, {31'd0, sel_busy & sel_done}, 32'd0);
      if (sel_done) lat = i;
      else begin
        if (sel_busy) busy_cnt++;
        check({tag, "_hold_S"}, {16'd0, sel_s}, {16'd0, last_s[which]});
        A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom); resta = 1'($urandom);
        if (pulse && i == 1) A = 16'h00AA;
        if (pulse) set_start(which, i == 1);
        @(negedge clk);
      end
    end
    set_start(which, 1'b0);
    check({tag, "_latency"}, lat, n + 1);
    check({tag, "_busy_cycles"}, busy_cnt, n);
    check({tag, "_S"}, {16'd0, sel_s}, {16'd0, es});
    check({tag, "_C_out"}, {31'd0, sel_co}, {31'd0, ec});
    check({tag, "_V"}, {31'd0, sel_v}, {31'd0, ev});
    last_s[which] = es;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      extra += int'(sel_done) + int'(sel_busy);
    end
    check({tag, "_no_second_op"}, extra, 0);
  endtask

  task automatic run_random(input int which, input int count);
    int w;
    logic [15:0] a, b;
    logic cin, rs;
    logic [17:0] r;
    w = (which == 2) ? 16 : 8;
    for (int k = 0; k < count; k++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); rs = 1'($urandom);
      if (w == 8) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
      r = model(w, a, b, cin, rs);
      run_op(which, a, b, cin, rs, r[15:0], r[16], r[17], 1'b0, $sformatf("rand%0d_%0d", which, k));
    end
  endtask

  initial begin
    int dones;
    for (int i = 0; i < 3; i++) last_s[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_S", {24'd0, s_m}, 32'd0);
    check("rst_C_out", {31'd0, co_m}, 32'd0);
    check("rst_V", {31'd0, v_m}, 32'd0);
    check("rst_busy", {31'd0, busy_m}, 32'd0);
    check("rst_done", {31'd0, done_m}, 32'd0);
    check("rst_state", {30'd0, st_m}, 32'd0);
    rst = 1'b0;

    run_op(0, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0, "add_wrap");
    run_op(0, 16'hFF, 16'hFF, 1'b1, 1'b0, 16'hFF, 1'b1, 1'b0, 1'b0, "add_ff_ff_c1");
    run_op(0, 16'h05, 16'h07, 1'b1, 1'b1, 16'hFE, 1'b0, 1'b0, 1'b0, "sub_5_7");
    run_op(0, 16'h80, 16'h01, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0, "sub_80_1");
    run_op(0, 16'h10, 16'h20, 1'b0, 1'b0, 16'h30, 1'b0, 1'b0, 1'b1, "ignore_start");

    // Reset during the second RUN cycle aborts the operation.
    sel = 0;
    @(negedge clk);
    A = 16'h33; B = 16'h11; C_in = 1'b0; resta = 1'b0; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_S", {24'd0, s_m}, 32'd0);
    check("midrst_C_out", {31'd0, co_m}, 32'd0);
    check("midrst_V", {31'd0, v_m}, 32'd0);
    check("midrst_busy", {31'd0, busy_m}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_s[i] = '0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      dones += int'(done_m);
      @(negedge clk);
    end
    check("midrst_no_done", dones, 0);
    run_op(0, 16'h01, 16'h02, 1'b0, 1'b0, 16'h03, 1'b0, 1'b0, 1'b0, "after_rst");

    run_op(1, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0, "d8_add_ovf");
    run_op(1, 16'h80, 16'h01, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0, "d8_sub");
    run_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "d16_add_ovf");
    run_op(2, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, "d16_sub");
    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "d16_wrap");

    run_random(0, 200);
    run_random(1, 1000);
    run_random(2, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
